// File: rtl/fuzzy_defuzz.sv
// Singleton-centroid defuzzifier: accumulates sum(mu*c) and sum(mu) over a frame,
// then divides with a bit-serial restoring divider and presents a saturated Q7.0 result.
module fuzzy_defuzz #(
  parameter int N_RULES = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_mu,
  input  logic signed [7:0] in_c,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] out_crisp,
  output logic              out_zero,
  output logic              out_err
);
  localparam int NUM_W = 24 + $clog2(N_RULES);
  localparam int DEN_W = 16 + $clog2(N_RULES);
  localparam int BC_W  = $clog2(N_RULES + 1);
  localparam int DC_W  = $clog2(NUM_W);

  typedef enum logic [1:0] {ACC, DIV, OUT} state_t;
  state_t state;

  logic signed [NUM_W-1:0] num;
  logic [DEN_W-1:0]        den;
  logic [BC_W-1:0]         bcnt;
  logic [NUM_W-1:0]        dvd;
  logic [DEN_W-1:0]        rem;
  logic [DC_W-1:0]         dcnt;
  logic                    neg;
  logic signed [7:0]       crisp;
  logic                    zero, err;

  logic [15:0]             mu_c;
  logic signed [23:0]      mu_s, c_s, prod;
  logic signed [NUM_W-1:0] num_nxt;
  logic [DEN_W-1:0]        den_nxt;
  logic [BC_W-1:0]         bcnt_nxt;
  logic [NUM_W-1:0]        num_abs;
  logic [DEN_W:0]          rem_sh, rem_dif;
  logic                    ge;
  logic [NUM_W-1:0]        q_fin;
  logic [7:0]              sat;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign out_crisp = crisp;
  assign out_zero  = zero;
  assign out_err   = err;

  // Strength is Q1.15; anything at or above 1.0 is pinned just below it.
  assign mu_c     = in_mu[15] ? 16'h7FFF : in_mu;
  assign mu_s     = {8'b0, mu_c};
  assign c_s      = {{16{in_c[7]}}, in_c};
  assign prod     = mu_s * c_s;
  assign num_nxt  = num + {{(NUM_W-24){prod[23]}}, prod};
  assign den_nxt  = den + {{(DEN_W-16){1'b0}}, mu_c};
  assign bcnt_nxt = bcnt + 1'b1;
  assign num_abs  = num_nxt[NUM_W-1] ? NUM_W'(-num_nxt) : NUM_W'(num_nxt);

  // One restoring-division step: dividend shifts out MSB first, quotient shifts in at LSB.
  assign rem_sh  = {rem, dvd[NUM_W-1]};
  assign ge      = (rem_sh >= {1'b0, den});
  assign rem_dif = rem_sh - {1'b0, den};
  assign q_fin   = {dvd[NUM_W-2:0], ge};

  always_comb begin
    sat = 8'h00;
    if (!neg) sat = (q_fin > NUM_W'(127)) ? 8'h7F : q_fin[7:0];
    else      sat = (q_fin > NUM_W'(127)) ? 8'h80 : 8'(-q_fin[7:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      num   <= '0;
      den   <= '0;
      bcnt  <= '0;
      dvd   <= '0;
      rem   <= '0;
      dcnt  <= '0;
      neg   <= 1'b0;
      crisp <= '0;
      zero  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ACC: if (in_valid) begin
          num  <= num_nxt;
          den  <= den_nxt;
          bcnt <= bcnt_nxt;
          if (in_last || bcnt_nxt == BC_W'(N_RULES)) begin
            state <= DIV;
            err   <= !in_last;
            dvd   <= num_abs;
            neg   <= num_nxt[NUM_W-1];
            rem   <= '0;
            dcnt  <= '0;
          end
        end
        DIV: begin
          dvd  <= q_fin;
          rem  <= ge ? rem_dif[DEN_W-1:0] : rem_sh[DEN_W-1:0];
          dcnt <= dcnt + 1'b1;
          // Zero denominator still runs the full divide so latency is data-independent.
          if (dcnt == DC_W'(NUM_W-1)) begin
            state <= OUT;
            zero  <= (den == '0);
            crisp <= (den == '0) ? 8'sd0 : $signed(sat);
          end
        end
        OUT: if (out_ready) begin
          state <= ACC;
          num   <= '0;
          den   <= '0;
          bcnt  <= '0;
          err   <= 1'b0;
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule
